// File: rtl/outlier_stream_reader.sv
// Drains the Controller's outlier-position FIFO onto a valid/ready stream,
// holding back the newest word until it is known whether it is the last one.
module outlier_stream_reader #(
  parameter int N           = 16,
  parameter int QUEUE_DEPTH = 4
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           start,
  input  logic           ctrl_done,
  input  logic           fifo_empty,
  input  logic [N-1:0]   fifo_dout,
  output logic           read_fifo,
  output logic [N-1:0]   m_data,
  output logic           m_valid,
  output logic           m_last,
  input  logic           m_ready,
  output logic [2*N-1:0] outlier_count,
  output logic           busy,
  output logic           finished
);

  localparam int AW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_FLUSH, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [N-1:0]     mem_q [QUEUE_DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    occ_q, occ_d;
  logic             inflight_q;
  logic [1:0]       done_q;
  logic [2*N-1:0]   cnt_q, cnt_d;

  logic             in_drain, in_flush, start_ok;
  logic             push, pop, end_cond;
  logic [CW:0]      demand;

  assign in_drain = (state_q == S_DRAIN);
  assign in_flush = (state_q == S_FLUSH);
  assign start_ok = start & ((state_q == S_IDLE) | (state_q == S_DONE));

  // The in-flight word already owns a queue slot, so it is counted here.
  assign demand    = {1'b0, occ_q} + {{CW{1'b0}}, inflight_q};
  assign read_fifo = in_drain & ~fifo_empty & (demand < (CW+1)'(QUEUE_DEPTH));

  assign push     = inflight_q;
  assign end_cond = done_q[1] & fifo_empty & ~inflight_q;

  // A lone word in DRAIN may still be followed by another, so it waits.
  assign m_valid = (occ_q >= CW'(2)) | ((occ_q == CW'(1)) & in_flush);
  assign m_last  = (occ_q == CW'(1)) & in_flush;
  assign m_data  = m_valid ? mem_q[rd_ptr_q] : '0;
  assign pop     = m_valid & m_ready;

  assign outlier_count = cnt_q;
  assign busy          = in_drain | in_flush;
  assign finished      = (state_q == S_DONE);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_DRAIN;
      S_DRAIN: if (end_cond) state_d = S_FLUSH;
      S_FLUSH: if ((occ_q == '0) || (pop && m_last)) state_d = S_DONE;
      S_DONE:  if (start) state_d = S_DRAIN;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    cnt_d    = cnt_q;
    if (start_ok) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
      cnt_d    = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop)      occ_d = occ_q + CW'(1);
      else if (!push && pop) occ_d = occ_q - CW'(1);
      if (pop && !(&cnt_q)) cnt_d = cnt_q + (2*N)'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      inflight_q <= 1'b0;
      done_q     <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      inflight_q <= read_fifo;
      done_q     <= {done_q[0], ctrl_done};
      cnt_q      <= cnt_d;
    end
  end

  // Storage needs no reset: m_data is masked whenever the queue is not presenting.
  always_ff @(posedge clock) begin
    if (push && !start_ok) mem_q[wr_ptr_q] <= fifo_dout;
  end

endmodule

// File: doc/outlier_stream_reader.md
Name: outlier_stream_reader

Overview:
- Consumer end of the Controller's outlier-position FIFO: issues `read_fifo`, captures the position words and drains them onto a valid/ready stream.
- `m_last` marks the final outlier of a point cloud.
- Sits between the Controller outputs (`outlier_pos_fifo`, `empty`, `done`) and the DMA/host write path.
- Counts emitted outliers and reports completion.

Parameters:
- N, 16, width of one outlier position word (Controller FIFO dout width).
- QUEUE_DEPTH, 4, internal staging queue entries; power of two, ≥2.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse: begin draining a new point cloud (ignored unless IDLE or DONE).
- ctrl_done  input  1  Controller `done`, level.
- fifo_empty  input  1  Controller FIFO `empty`.
- fifo_dout  input  N  Controller FIFO `outlier_pos_fifo`; valid exactly 1 cycle after a `read_fifo` high cycle.
- read_fifo  output  1  FIFO read enable.
- m_data  output  N  outlier position.
- m_valid  output  1  stream valid.
- m_last  output  1  last outlier of this cloud; qualified by m_valid.
- m_ready  input  1  downstream ready.
- outlier_count  output  2N  outliers emitted since last start.
- busy  output  1  high in DRAIN/FLUSH.
- finished  output  1  high in DONE.

Behaviour:
- Reset (reset=0, async): state=IDLE; all outputs 0; queue, in-flight flag and done pipeline cleared.
- States:
  - IDLE→DRAIN on start. On start: outlier_count←0, queue cleared.
  - DRAIN→FLUSH when end_cond.
  - FLUSH→DONE after the m_last handshake, or immediately if the queue is empty.
  - DONE→DRAIN on start.
- done_q: ctrl_done registered through 2 flops. This covers the 1-cycle FIFO `empty` update lag after the last write.
- end_cond = done_q[1] & fifo_empty & !inflight.
- Read issue, DRAIN only:
  - read_fifo = !fifo_empty & (occupancy + inflight < QUEUE_DEPTH).
  - inflight ← read_fifo.
  - Data is pushed into the queue the cycle after read_fifo (1-cycle latency).
  - read_fifo is never high while fifo_empty=1, and never high outside DRAIN.
- Output gating (last-item hold-back):
  - m_valid = (occupancy ≥ 2) | (occupancy == 1 & state==FLUSH).
  - m_data = queue head.
  - m_last = (occupancy == 1) & (state == FLUSH).
  - A lone item in DRAIN is held, because it may not be the last.
- Handshake:
  - Pop on m_valid & m_ready.
  - m_data, m_valid and m_last stay stable while m_valid & !m_ready.
  - A simultaneous push and pop leaves occupancy unchanged.
  - Queue pointers wrap modulo QUEUE_DEPTH.
  - The queue never overflows, because the read gating counts the in-flight word.
- outlier_count:
  - Increments on each handshake; saturates at all-ones (no wrap).
  - Holds its value in DONE until the next start.
- Zero outliers: the block reaches DONE with no beat emitted and outlier_count=0; m_last is never asserted.
- ctrl_done deasserting mid-run: done_q follows it; the block stays in DRAIN.
- start during DRAIN or FLUSH is ignored.
- reset low mid-operation aborts immediately to IDLE. Stream outputs drop the same cycle (async); no partial beat is retained.
- busy = state ∈ {DRAIN, FLUSH}; finished = state==DONE.

Test Plan:
1. Reset, start, FIFO preloaded with 3 words {5,9,12}, ctrl_done high, m_ready=1 → beats 5, 9, 12 with m_last only on 12; outlier_count=3; finished=1.
2. Zero outliers: start, fifo_empty=1, ctrl_done rises → no m_valid ever; DONE reached 3 cycles after ctrl_done; outlier_count=0.
3. Backpressure: 10 words, m_ready toggles 1-0-0-1 → read_fifo stalls once occupancy+inflight=4; no word lost or duplicated; data held stable while stalled; outlier_count=10.
4. Late-end hold-back: 1 word present, ctrl_done low 20 cycles → m_valid stays 0. Raise ctrl_done → single beat with m_last=1.
5. Word arriving in the same cycle ctrl_done rises (empty lag) → the word is still read and emitted. m_last is on that word, not on the earlier one.
6. reset driven low mid-stream after 2 of 6 beats → outputs 0 immediately. A new start after release counts from 0.
